// File: rtl/arm_pio_pkg.sv
// Shared register map and parameter encodings for the Avalon-MM PIO input block.
package arm_pio_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,
        ADDR_RSVD = 2'd1,
        ADDR_MASK = 2'd2,
        ADDR_EDGE = 2'd3
    } pio_addr_e;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchroniser chain plus registered edge detector for the PIO input bits.
module pio_sync_edge
    import arm_pio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] edge_det
);

    logic [WIDTH-1:0] sync_r [SYNC_STAGES];
    logic [WIDTH-1:0] data_d_r;
    logic [WIDTH-1:0] edge_r;
    logic [WIDTH-1:0] edge_s;

    // Metastability chain; reset clears any edge still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            sync_r[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    assign data = sync_r[SYNC_STAGES-1];

    // Edge polarity selection between current and previous synchronised sample.
    always_comb begin
        edge_s = {WIDTH{1'b0}};
        case (EDGE_TYPE)
            EDGE_RISE: edge_s = data & ~data_d_r;
            EDGE_FALL: edge_s = ~data & data_d_r;
            EDGE_ANY:  edge_s = data ^ data_d_r;
            default:   edge_s = {WIDTH{1'b0}};
        endcase
    end

    // Previous-sample register and registered edge strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_d_r <= {WIDTH{1'b0}};
            edge_r   <= {WIDTH{1'b0}};
        end else begin
            data_d_r <= data;
            edge_r   <= edge_s;
        end
    end

    assign edge_det = edge_r;

endmodule

// File: rtl/arm_pio_in_irq.sv
// Avalon-MM PIO input port with edge capture and maskable level/edge interrupt.
module arm_pio_in_irq
    import arm_pio_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE,
    parameter int IRQ_MODE    = IRQ_EDGE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("arm_pio_in_irq: WIDTH must be in 1..32");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("arm_pio_in_irq: SYNC_STAGES must be in 2..4");
    end
    if (EDGE_TYPE < EDGE_RISE || EDGE_TYPE > EDGE_ANY) begin : g_bad_edge
        $error("arm_pio_in_irq: EDGE_TYPE must be 0, 1 or 2");
    end
    if (IRQ_MODE != IRQ_LEVEL && IRQ_MODE != IRQ_EDGE) begin : g_bad_irq
        $error("arm_pio_in_irq: IRQ_MODE must be 0 or 1");
    end

    logic [WIDTH-1:0] data_s;
    logic [WIDTH-1:0] edge_s;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] edgecap_r;
    logic [WIDTH-1:0] edgecap_next_s;
    logic [WIDTH-1:0] src_s;
    logic [31:0]      readdata_next_s;
    logic [31:0]      readdata_r;
    logic             irq_r;
    logic             unused_s;

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk      (clk),
        .reset    (reset),
        .in_port  (in_port),
        .data     (data_s),
        .edge_det (edge_s)
    );

    // Decode is read-independent, so the strobe and high write bits are otherwise unused.
    assign unused_s = ^{read, writedata};

    // Write-1-to-clear applied first, then new edges OR'd in so a set wins over a clear.
    always_comb begin
        edgecap_next_s = edgecap_r;
        if (write && (address == ADDR_EDGE)) begin
            edgecap_next_s = edgecap_r & ~writedata[WIDTH-1:0];
        end else begin
            edgecap_next_s = edgecap_r;
        end
        edgecap_next_s = edgecap_next_s | edge_s;
    end

    // Read mux; unused upper bits stay zero.
    always_comb begin
        readdata_next_s = 32'd0;
        case (address)
            ADDR_DATA: readdata_next_s[WIDTH-1:0] = data_s;
            ADDR_MASK: readdata_next_s[WIDTH-1:0] = mask_r;
            ADDR_EDGE: readdata_next_s[WIDTH-1:0] = edgecap_r;
            default:   readdata_next_s = 32'd0;
        endcase
    end

    // Interrupt source selection.
    always_comb begin
        src_s = {WIDTH{1'b0}};
        if (IRQ_MODE == IRQ_LEVEL) begin
            src_s = data_s;
        end else begin
            src_s = edgecap_r;
        end
    end

    // Control/status registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_r     <= {WIDTH{1'b0}};
            edgecap_r  <= {WIDTH{1'b0}};
            readdata_r <= 32'd0;
            irq_r      <= 1'b0;
        end else begin
            if (write && (address == ADDR_MASK)) begin
                mask_r <= writedata[WIDTH-1:0];
            end
            edgecap_r  <= edgecap_next_s;
            readdata_r <= readdata_next_s;
            irq_r      <= |(src_s & mask_r);
        end
    end

    assign readdata = readdata_r;
    assign irq      = irq_r;

endmodule

// File: tb/tb_arm_pio_in_irq.sv
// Scoreboard bench for arm_pio_in_irq: four parameterisations share one Avalon bus.
module tb_arm_pio_in_irq;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] in_port;
    logic [31:0] rd_dut, rd_lvl, rd_any, rd_fall;
    logic        irq_dut, irq_lvl, irq_any, irq_fall;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          sel;
        logic [31:0] exp;
        string       tag;
    } sb_t;
    sb_t sb_q[$];

    always #5 clk = ~clk;

    arm_pio_in_irq u_dut (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .readdata(rd_dut), .in_port(in_port), .irq(irq_dut)
    );

    arm_pio_in_irq #(.WIDTH(8), .IRQ_MODE(0)) u_lvl (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .readdata(rd_lvl), .in_port(in_port[7:0]), .irq(irq_lvl)
    );

    arm_pio_in_irq #(.EDGE_TYPE(2)) u_any (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .readdata(rd_any), .in_port(in_port), .irq(irq_any)
    );

    arm_pio_in_irq #(.EDGE_TYPE(1)) u_fall (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .readdata(rd_fall), .in_port(in_port), .irq(irq_fall)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_of(input int sel);
        case (sel)
            0:       return rd_dut;
            1:       return rd_lvl;
            2:       return rd_any;
            3:       return rd_fall;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pop_check();
        sb_t e;
        e = sb_q.pop_front();
        check_val(e.tag, rd_of(e.sel), e.exp);
    endtask

    task automatic rd(input int sel, input logic [1:0] addr, input logic [31:0] exp, input string tag);
        address = addr;
        read    = 1'b1;
        sb_q.push_back('{sel: sel, exp: exp, tag: tag});
        tick();
        read = 1'b0;
        pop_check();
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        address   = addr;
        writedata = data;
        write     = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic rdwr(input int sel, input logic [1:0] addr, input logic [31:0] data,
                        input logic [31:0] exp, input string tag);
        address   = addr;
        writedata = data;
        read      = 1'b1;
        write     = 1'b1;
        sb_q.push_back('{sel: sel, exp: exp, tag: tag});
        tick();
        read  = 1'b0;
        write = 1'b0;
        pop_check();
    endtask

    initial begin
        reset     = 1'b1;
        in_port   = 32'd0;
        address   = 2'd0;
        read      = 1'b0;
        write     = 1'b0;
        writedata = 32'd0;
        wait_n(2);
        check_val("rst_rdata", rd_dut, 32'd0);
        check_val("rst_irq", {31'd0, irq_dut}, 32'd0);
        reset = 1'b0;
        wait_n(4);
        rd(0, 2'd3, 32'd0, "no_spurious_edge");

        // Data path latency: visible exactly SYNC_STAGES edges after the change.
        in_port = 32'hA5A5_1234;
        tick();
        rd(0, 2'd0, 32'd0, "data_lat_early");
        rd(0, 2'd0, 32'hA5A5_1234, "data_lat");
        rd(1, 2'd0, 32'h0000_0034, "lvl_data_narrow");
        in_port = 32'd0;
        wait_n(6);
        wr(2'd3, 32'hFFFF_FFFF);
        rd(0, 2'd3, 32'd0, "ecap_clear_all");

        // Single-cycle pulse on bit 4, captured SYNC_STAGES+2 edges later.
        wr(2'd2, 32'h0000_0010);
        in_port = 32'h0000_0010;
        tick();
        in_port = 32'd0;
        wait_n(2);
        rd(0, 2'd3, 32'd0, "ecap_lat_early");
        rd(0, 2'd3, 32'h0000_0010, "ecap_pulse");
        check_val("irq_edge_set", {31'd0, irq_dut}, 32'd1);
        wr(2'd3, 32'h0000_0010);
        check_val("irq_one_behind", {31'd0, irq_dut}, 32'd1);
        rd(0, 2'd3, 32'd0, "ecap_w1c");
        check_val("irq_cleared", {31'd0, irq_dut}, 32'd0);

        // Capture and clear of bit 0 on the same edge.
        wr(2'd3, 32'hFFFF_FFFF);
        in_port = 32'h0000_0001;
        wait_n(3);
        wr(2'd3, 32'h0000_0001);
        rd(0, 2'd3, 32'h0000_0001, "set_priority");
        wr(2'd3, 32'h0000_0001);
        rd(0, 2'd3, 32'd0, "clear_after_prio");

        // Edge polarity across configurations.
        in_port = 32'h0000_0004;
        wait_n(6);
        wr(2'd3, 32'hFFFF_FFFF);
        in_port = 32'd0;
        wait_n(6);
        rd(2, 2'd3, 32'h0000_0004, "any_fall");
        rd(3, 2'd3, 32'h0000_0004, "fall_fall");
        rd(0, 2'd3, 32'd0, "rise_ignores_fall");
        wr(2'd3, 32'hFFFF_FFFF);
        in_port = 32'h0000_0004;
        wait_n(6);
        rd(3, 2'd3, 32'd0, "fall_ignores_rise");
        rd(2, 2'd3, 32'h0000_0004, "any_rise");
        rd(0, 2'd3, 32'h0000_0004, "rise_rise");

        // Level-mode interrupt on the narrow instance.
        wr(2'd2, 32'h0000_0001);
        in_port = 32'h0000_0081;
        wait_n(4);
        check_val("lvl_irq_set", {31'd0, irq_lvl}, 32'd1);
        rd(1, 2'd0, 32'h0000_0081, "lvl_data");
        wr(2'd2, 32'd0);
        check_val("lvl_irq_lag", {31'd0, irq_lvl}, 32'd1);
        tick();
        check_val("lvl_irq_clr", {31'd0, irq_lvl}, 32'd0);
        rd(1, 2'd2, 32'd0, "lvl_mask0");
        wr(2'd2, 32'hFFFF_FF01);
        rd(1, 2'd2, 32'h0000_0001, "lvl_mask_upper0");
        rd(0, 2'd2, 32'hFFFF_FF01, "mask_rd32");
        rdwr(0, 2'd2, 32'h0000_0055, 32'hFFFF_FF01, "rdwr_old_value");
        rd(0, 2'd2, 32'h0000_0055, "rdwr_new_value");
        wr(2'd1, 32'hFFFF_FFFF);
        rd(0, 2'd1, 32'd0, "reserved_zero");
        wr(2'd0, 32'd0);
        rd(0, 2'd0, 32'h0000_0081, "data_read_only");

        // Mid-stream reset with live mask, captured edges and an edge in flight.
        in_port = 32'd0;
        wait_n(6);
        wr(2'd3, 32'hFFFF_FFFF);
        wr(2'd2, 32'h0000_00FF);
        in_port = 32'h0000_0003;
        wait_n(6);
        rd(0, 2'd3, 32'h0000_0003, "pre_rst_ecap");
        check_val("pre_rst_irq", {31'd0, irq_dut}, 32'd1);
        in_port = 32'h0000_0007;
        tick();
        #2 reset = 1'b1;
        #1;
        check_val("rst_async_rdata", rd_dut, 32'd0);
        check_val("rst_async_irq", {31'd0, irq_dut}, 32'd0);
        in_port = 32'd0;
        wait_n(2);
        reset = 1'b0;
        wait_n(6);
        rd(0, 2'd3, 32'd0, "rst_discard_edge");
        rd(0, 2'd2, 32'd0, "rst_mask_zero");
        check_val("rst_irq_stays0", {31'd0, irq_dut}, 32'd0);

        // Input held high through reset release reports one rising edge.
        reset   = 1'b1;
        in_port = 32'h0000_0008;
        wait_n(2);
        reset = 1'b0;
        wait_n(6);
        rd(0, 2'd3, 32'h0000_0008, "rst_held_high");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/arm_pio_in_irq.md
ARM_PIO_IN_IRQ -- requirements
Module: arm_pio_in_irq

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, number of input bits (1..32).
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, input synchroniser depth (2..4).
REQ-003 SHALL provide parameter EDGE_TYPE, default 0, capture edge: 0 rising, 1 falling, 2 any.
REQ-004 SHALL provide parameter IRQ_MODE, default 1, interrupt source: 0 level (data & mask), 1 edge (edgecapture & mask).
REQ-005 SHALL provide port clk, input, 1, sole clock; one clock domain, rising edge.
REQ-006 SHALL provide port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL provide port address, input, 2, Avalon-MM word address.
REQ-008 SHALL provide port read, input, 1, read strobe.
REQ-009 SHALL provide port write, input, 1, write strobe.
REQ-010 SHALL provide port writedata, input, 32, write data.
REQ-011 SHALL provide port readdata, output, 32, registered read data.
REQ-012 SHALL provide port in_port, input, WIDTH, asynchronous external inputs.
REQ-013 SHALL provide port irq, output, 1, registered level interrupt.

Function
REQ-014 SHALL pass in_port through a SYNC_STAGES flip-flop chain; sync output is "data".
REQ-015 SHALL hold one further register of data ("data_d") for edge detection; edge = data & ~data_d (rising), ~data & data_d (falling), data ^ data_d (any).
REQ-016 SHALL map registers: 0 data (RO), 1 reserved (reads 0, writes ignored), 2 irqmask (RW), 3 edgecapture (read; write-1-to-clear).
REQ-017 SHALL register readdata every cycle from the address mux with read-independent decode, i.e. one-cycle read latency; bits [31:WIDTH] always 0.
REQ-018 SHALL set edgecapture bit n on the cycle after edge bit n is detected; bit stays set until cleared.
REQ-019 SHALL, on write to address 3, clear every edgecapture bit whose writedata bit is 1; bits with writedata 0 unchanged.
REQ-020 SHALL give set priority: edge detected on bit n in the same cycle as a clear of bit n leaves bit n set.
REQ-021 SHALL, on write to address 2, load irqmask <= writedata[WIDTH-1:0] at the next edge.
REQ-022 SHALL compute irq_next = |(src & irqmask), src per IRQ_MODE, and register it; irq is one cycle behind src/irqmask changes.
REQ-023 SHALL ignore writes to addresses 0 and 1; read and write asserted together both take effect (read returns pre-write value).
REQ-024 SHALL have total in_port-to-data latency SYNC_STAGES cycles and in_port-to-edgecapture latency SYNC_STAGES+2 cycles.

Reset
REQ-025 SHALL, while reset is high, asynchronously force readdata=0, irq=0, irqmask=0, edgecapture=0, sync chain=0, data_d=0.
REQ-026 SHALL not report a spurious edge after reset release when in_port is held 0; an input held 1 through reset release SHALL report a rising edge once synchronised (defined behaviour).
REQ-027 SHALL discard any edge in the sync chain when reset asserts mid-operation.

Structure
REQ-028 SHALL place register offsets (ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3) and EDGE_TYPE/IRQ_MODE encodings in shared package arm_pio_pkg.
REQ-029 SHALL implement synchroniser plus edge detector as sub-module pio_sync_edge (params WIDTH, SYNC_STAGES, EDGE_TYPE; outputs data, edge).
REQ-030 SHALL reject illegal parameter values at elaboration.

Verification
REQ-031 Reset: assert reset mid-stream with irqmask=0xFF, edgecapture=0x3 -> all regs and irq 0 immediately, read addr 3 returns 0.
REQ-032 Read latency: in_port=0xA5A5_1234 held, read addr 0 -> readdata=0xA5A5_1234 one cycle after read, after SYNC_STAGES settle.
REQ-033 Edge capture (EDGE_TYPE=0): pulse in_port[4] 0->1->0, irqmask=0x10 -> edgecapture=0x10, irq=1; write 0x10 to addr 3 -> edgecapture=0, irq=0 next cycle.
REQ-034 Set priority: rising edge on bit 0 same cycle as write 0x1 to addr 3 -> edgecapture bit 0 remains 1.
REQ-035 Level mode (IRQ_MODE=0, WIDTH=8): in_port=0x81, irqmask=0x01 -> irq=1; irqmask=0x00 -> irq=0; readdata[31:8]=0 throughout.
REQ-036 Any-edge (EDGE_TYPE=2): in_port[2] 1->0 -> edgecapture=0x4; falling-only config ignores 0->1 transitions.
